// File: rtl/bcd_serial_addsub_if.sv
// Bundles the request and result signals of the digit-serial BCD add/sub unit.
// Latency: none; this is wiring only.
// Backpressure: none; start is only taken while the unit is idle, otherwise it is dropped.
interface bcd_serial_addsub_if #(
  parameter int DIGITS = 4
);
  logic                  start;
  logic                  op_sub;
  logic [4*DIGITS-1:0]   a;
  logic [4*DIGITS-1:0]   b;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   result;
  logic                  cout;
  logic                  neg;
  logic                  err;

  // Requester side: drives the operands and the start request.
  modport master (
    output start, op_sub, a, b,
    input  busy, done, result, cout, neg, err
  );

  // Unit side: consumes the request and returns the result.
  modport slave (
    input  start, op_sub, a, b,
    output busy, done, result, cout, neg, err
  );
endinterface

// File: rtl/bcd_serial_addsub.sv
// Digit-serial BCD adder/subtractor (nines' complement + initial carry); optional sign fix via BCD_SIGN_FIX_EN.
// Latency: done DIGITS+1 cycles after accept, 2*DIGITS+1 with sign fix on a negative difference, 1 for bad operands.
// Backpressure: none; start is accepted only in IDLE and ignored otherwise (not queued).
module bcd_serial_addsub #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bcd_serial_addsub_if.slave    bus
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            c_q, c_d;
  logic            sub_q, sub_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    result_q, result_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
`ifdef BCD_SIGN_FIX_EN
  logic            neg_q, neg_d;
`endif

  logic [3:0]      dig_x;
  logic [3:0]      dig_m;
  logic [4:0]      z;
  logic            gt9;
  logic [3:0]      sum_dig;
  logic            last;
  logic            bad_operand;

  // Single-digit datapath: ADD uses a[i] and (complemented) b[i]; FIX recomplements result[i].
  always_comb begin
    dig_x = 4'd0;
    dig_m = 4'd0;
    if (state_q == FIX) begin
      dig_x = 4'd0;
      dig_m = 4'd9 - result_q[4*int'(idx_q) +: 4];
    end else begin
      dig_x = a_q[4*int'(idx_q) +: 4];
      dig_m = sub_q ? (4'd9 - b_q[4*int'(idx_q) +: 4]) : b_q[4*int'(idx_q) +: 4];
    end
    z       = {1'b0, dig_x} + {1'b0, dig_m} + {4'd0, c_q};
    gt9     = (z > 5'd9);
    sum_dig = gt9 ? (z[3:0] + 4'd6) : z[3:0];
    last    = (idx_q == IW'(DIGITS - 1));
  end

  // Operand check at acceptance: any digit above 9 in a or b is an error.
  always_comb begin
    bad_operand = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bus.a[4*k +: 4] > 4'd9 || bus.b[4*k +: 4] > 4'd9) begin
        bad_operand = 1'b1;
      end
    end
  end

  // Next-state and register updates for the IDLE/ADD/FIX/DONE sequencer.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    c_d      = c_q;
    sub_d    = sub_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    cout_d   = cout_q;
    err_d    = err_q;
    done_d   = 1'b0;
`ifdef BCD_SIGN_FIX_EN
    neg_d    = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d      = bus.a;
          b_d      = bus.b;
          sub_d    = bus.op_sub;
          idx_d    = '0;
          c_d      = bus.op_sub;
          result_d = '0;
          cout_d   = 1'b0;
          err_d    = bad_operand;
`ifdef BCD_SIGN_FIX_EN
          neg_d    = 1'b0;
`endif
          state_d  = bad_operand ? DONE : ADD;
        end
      end
      ADD: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (idx_q == IW'(k)) result_d[4*k +: 4] = sum_dig;
        end
        c_d   = gt9;
        idx_d = idx_q + 1'b1;
        if (last) begin
          cout_d  = gt9;
          idx_d   = '0;
          state_d = DONE;
`ifdef BCD_SIGN_FIX_EN
          // Borrow out of a subtraction: convert the ten's complement back to a magnitude.
          if (sub_q && !gt9) begin
            c_d     = 1'b1;
            neg_d   = 1'b1;
            state_d = FIX;
          end
`endif
        end
      end
`ifdef BCD_SIGN_FIX_EN
      FIX: begin
        for (int k = 0; k < DIGITS; k++) begin
          if (idx_q == IW'(k)) result_d[4*k +: 4] = sum_dig;
        end
        c_d   = gt9;
        idx_d = idx_q + 1'b1;
        if (last) begin
          // Carry out of the top digit is meaningless for the magnitude.
          c_d     = 1'b0;
          idx_d   = '0;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      c_q      <= 1'b0;
      sub_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BCD_SIGN_FIX_EN
      neg_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      c_q      <= c_d;
      sub_q    <= sub_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      err_q    <= err_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef BCD_SIGN_FIX_EN
      neg_q    <= neg_d;
`endif
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.cout   = cout_q;
  assign bus.err    = err_q;
`ifdef BCD_SIGN_FIX_EN
  assign bus.neg    = neg_q;
`else
  assign bus.neg    = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Bench for bcd_serial_addsub: directed cases plus random operands against an integer-arithmetic model.
// Latency: measured from the accepting edge to the first sample with done high.
// Backpressure: exercises start pulses while busy, which must be ignored.
module tb_bcd_serial_addsub;

  localparam int D = 4;
  localparam int W = 4 * D;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  bcd_serial_addsub_if #(.DIGITS(D)) bus ();

  bcd_serial_addsub #(.DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int bcd2int(input logic [W-1:0] v);
    int r;
    r = 0;
    for (int k = D - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  function automatic logic [W-1:0] int2bcd(input int x);
    logic [W-1:0] r;
    int           t;
    t = x;
    r = '0;
    for (int k = 0; k < D; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] rand_bcd();
    logic [W-1:0] r;
    r = '0;
    for (int k = 0; k < D; k++) r[4*k +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  // Decimal reference: plain integer sum/difference modulo 10^D.
  task automatic model(input logic [W-1:0] av, input logic [W-1:0] bv, input logic sub,
                       output logic [W-1:0] r, output logic co, output logic ng,
                       output logic er, output int lat);
    int pw;
    int ai;
    int bi;
    er = 1'b0;
    for (int k = 0; k < D; k++) begin
      if (av[4*k +: 4] > 4'd9 || bv[4*k +: 4] > 4'd9) er = 1'b1;
    end
    pw  = 10 ** D;
    r   = '0;
    co  = 1'b0;
    ng  = 1'b0;
    lat = D + 1;
    if (er) begin
      lat = 1;
    end else begin
      ai = bcd2int(av);
      bi = bcd2int(bv);
      if (!sub) begin
        co = (ai + bi >= pw);
        r  = int2bcd((ai + bi) % pw);
      end else begin
        co = (ai >= bi);
        r  = int2bcd((ai - bi + pw) % pw);
`ifdef BCD_SIGN_FIX_EN
        if (ai < bi) begin
          r   = int2bcd(bi - ai);
          ng  = 1'b1;
          lat = 2 * D + 1;
        end
`endif
      end
    end
  endtask

  // Called at a negedge; returns at the negedge of the done cycle so a following
  // call asserts start in the cycle right after done.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic sub, input logic poke);
    logic [W-1:0] er_r;
    logic         er_c;
    logic         er_n;
    logic         er_e;
    int           er_l;
    int           lat;
    model(av, bv, sub, er_r, er_c, er_n, er_e, er_l);
    bus.a      = av;
    bus.b      = bv;
    bus.op_sub = sub;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, ".busy_accept"}, 32'(bus.busy), 32'd1);
    chk({tag, ".done_low_accept"}, 32'(bus.done), 32'd0);
    bus.a      = rand_bcd();
    bus.b      = rand_bcd();
    if (poke) begin
      bus.op_sub = ~sub;
      bus.start  = 1'b1;
    end else begin
      bus.start  = 1'b0;
    end
    lat = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge clk);
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        lat = cyc;
        break;
      end
    end
    chk({tag, ".latency"}, 32'(lat), 32'(er_l));
    chk({tag, ".result"}, 32'(bus.result), 32'(er_r));
    chk({tag, ".cout"}, 32'(bus.cout), 32'(er_c));
    chk({tag, ".neg"}, 32'(bus.neg), 32'(er_n));
    chk({tag, ".err"}, 32'(bus.err), 32'(er_e));
    chk({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int           seen;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W-1:0] hold;
    n_cmp      = 0;
    n_err      = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.op_sub = 1'b0;
    bus.a      = '0;
    bus.b      = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.busy", 32'(bus.busy), 32'd0);
    chk("rst.done", 32'(bus.done), 32'd0);
    chk("rst.result", 32'(bus.result), 32'd0);
    chk("rst.cout", 32'(bus.cout), 32'd0);
    chk("rst.neg", 32'(bus.neg), 32'd0);
    chk("rst.err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("add_1234_5678", 16'h1234, 16'h5678, 1'b0, 1'b0);
    chk("add_1234_5678.const", 32'(bus.result), 32'h6912);
    run_op("add_9999_0001", 16'h9999, 16'h0001, 1'b0, 1'b0);
    run_op("sub_5000_1234", 16'h5000, 16'h1234, 1'b1, 1'b0);
    chk("sub_5000_1234.const", 32'(bus.result), 32'h3766);
    run_op("sub_1234_5000", 16'h1234, 16'h5000, 1'b1, 1'b0);
    run_op("bad_12A4", 16'h12A4, 16'h0000, 1'b0, 1'b1);
    run_op("add_poke", 16'h4321, 16'h1111, 1'b0, 1'b1);
    run_op("sub_equal", 16'h0777, 16'h0777, 1'b1, 1'b0);
    run_op("sub_0_9999", 16'h0000, 16'h9999, 1'b1, 1'b1);
    run_op("bad_b", 16'h0001, 16'hF000, 1'b1, 1'b0);

    // Reset during the third ADD digit must abort without a done pulse.
    bus.a      = 16'h2468;
    bus.b      = 16'h1357;
    bus.op_sub = 1'b0;
    bus.start  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst.busy", 32'(bus.busy), 32'd0);
    chk("midrst.result", 32'(bus.result), 32'd0);
    chk("midrst.done", 32'(bus.done), 32'd0);
    rst_n = 1'b1;
    seen  = 0;
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.done) seen++;
    end
    chk("midrst.no_done", 32'(seen), 32'd0);
    run_op("after_rst", 16'h2468, 16'h1357, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      ra = rand_bcd();
      rb = rand_bcd();
      if ($urandom_range(0, 7) == 0) ra[4*$urandom_range(0, D-1) +: 4] = 4'($urandom_range(10, 15));
      run_op($sformatf("rnd%0d", n), ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    // Result is held while idle.
    hold = bus.result;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("idle.result_held", 32'(bus.result), 32'(hold));
    chk("idle.busy", 32'(bus.busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
